// File: rtl/av_method_arbiter.sv
// -----------------------------------------------------------------------------
// av_method_arbiter
//
// Round-robin arbiter sharing one ActionValue method of a compiled BSV module
// (RDY/EN/argument/result port group) among NREQ requesters. At most one call
// is issued per cycle, EN_m is only raised while RDY_m is high, and the method
// result is captured into a one-entry response register tagged with the ID of
// the requester that made the call.
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RST_N        synchronous active-low reset
//   req_valid    per-requester call request
//   req_arg      flattened arguments, requester i at [i*AW +: AW]
//   req_grant    one-hot, the call from requester i is accepted this cycle
//   RDY_m        method ready from the wrapped module
//   EN_m         method enable to the wrapped module
//   m_arg        method argument to the wrapped module
//   m_result     method result, valid in the cycle EN_m is high
//   resp_valid   response register holds data
//   resp_data    captured method result
//   resp_id      requester that issued the captured call
//   resp_ready   consumer accepts the response
//   issue_count  total accepted calls, wraps modulo 2^CW
// -----------------------------------------------------------------------------
module av_method_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2,
  parameter int AW   = 32,
  parameter int RW   = 32,
  parameter int CW   = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_arg,
  output logic [NREQ-1:0]   req_grant,
  input  logic              RDY_m,
  output logic              EN_m,
  output logic [AW-1:0]     m_arg,
  input  logic [RW-1:0]     m_result,
  output logic              resp_valid,
  output logic [RW-1:0]     resp_data,
  output logic [IW-1:0]     resp_id,
  input  logic              resp_ready,
  output logic [CW-1:0]     issue_count
);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic          found;
  logic          can_issue;

  // A response that is being drained this cycle frees the register, so a new
  // call may be issued in the same cycle without a bubble.
  assign can_issue = RDY_m && (!resp_valid || resp_ready);

  // Winner: first requesting index at or above rr_ptr, wrapping modulo NREQ.
  // Depends only on rr_ptr and req_valid, never on m_result.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment would infer a latch.
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    EN_m      = 1'b0;
    req_grant = '0;
    m_arg     = '0;
    if (can_issue && found) begin
      EN_m              = 1'b1;
      req_grant[winner] = 1'b1;
      m_arg             = req_arg[int'(winner)*AW +: AW];
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!RST_N) begin
      // NOTE: the datapath registers resp_data/resp_id are reset as well, so
      // the response port reads as zero after reset rather than X.
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_id     <= '0;
      issue_count <= '0;
      rr_ptr      <= '0;
    end else if (EN_m) begin
      resp_valid  <= 1'b1;
      resp_data   <= m_result;
      resp_id     <= winner;
      issue_count <= issue_count + CW'(1);
      rr_ptr      <= (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
    end else if (resp_valid && resp_ready) begin
      resp_valid  <= 1'b0;
    end
  end

endmodule
